// File: rtl/if_fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package if_fetch_pkg;

  localparam int INST_ADDR_W = 32;
  localparam int INST_W      = 32;

  localparam logic [INST_ADDR_W-1:0] PC_RESET_VEC = 32'h1c00_0000;

  typedef struct packed {
    logic [INST_ADDR_W-1:0] pc;
    logic [INST_W-1:0]      inst;
  } fetch_entry_t;

  function automatic logic [INST_ADDR_W-1:0] word_align(input logic [INST_ADDR_W-1:0] addr);
    return {addr[INST_ADDR_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_fetch_inst_fifo.sv
// Small synchronous FIFO of {pc, inst} pairs; the head is visible combinationally
// so a word pushed in cycle t is presented in t+1.
module if_fetch_inst_fifo
  import if_fetch_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  fetch_entry_t  wr_data,
  output fetch_entry_t  rd_data,
  output logic [CW-1:0] count,
  output logic          empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  fetch_entry_t  mem [DEPTH];
  logic [PW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0] count_reg;
  logic          full, do_push, do_pop;

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == CW'(DEPTH));
  assign count   = count_reg;
  assign do_push = push && !flush && !full;
  assign do_pop  = pop && !flush && !empty;
  assign rd_data = empty ? '0 : mem[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push)
        wr_ptr_reg <= (wr_ptr_reg == PW'(DEPTH - 1)) ? '0 : wr_ptr_reg + 1'b1;
      if (do_pop)
        rd_ptr_reg <= (rd_ptr_reg == PW'(DEPTH - 1)) ? '0 : rd_ptr_reg + 1'b1;
      count_reg <= count_reg + CW'(do_push) - CW'(do_pop);
    end
  end

  // Payload storage carries no reset; occupancy is tracked by count_reg.
  always_ff @(posedge clk) begin
    if (do_push)
      mem[wr_ptr_reg] <= wr_data;
  end

endmodule

// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns the PC, issues credit-limited in-order fetches,
// buffers responses with their PCs and drops responses made stale by a redirect.
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter int                     DEPTH    = 2,
  parameter logic [INST_ADDR_W-1:0] RESET_PC = PC_RESET_VEC
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   redirect_i,
  input  logic [INST_ADDR_W-1:0] redirect_pc_i,
  output logic                   req_valid_o,
  input  logic                   req_ready_i,
  output logic [INST_ADDR_W-1:0] req_addr_o,
  input  logic                   rsp_valid_i,
  input  logic [INST_W-1:0]      rsp_data_i,
  output logic                   valid_o,
  input  logic                   ready_i,
  output logic [INST_ADDR_W-1:0] pc_o,
  output logic [INST_W-1:0]      inst_o
);

  localparam int CW = $clog2(DEPTH + 1);

  logic [INST_ADDR_W-1:0] pc_reg, pc_next;
  logic [INST_ADDR_W-1:0] rsp_pc_reg, rsp_pc_next;
  logic [CW-1:0]          outstanding_reg, outstanding_next;
  logic [CW-1:0]          discard_reg, discard_next;
  logic [CW-1:0]          count;
  logic [CW:0]            in_use;
  logic                   req_fire, push, pop, empty;
  fetch_entry_t           push_entry, head;

  // Credit covers both buffered words and words still in flight.
  assign in_use      = {1'b0, count} + {1'b0, outstanding_reg};
  assign req_valid_o = !rst && !redirect_i && (in_use < (CW + 1)'(DEPTH));
  assign req_addr_o  = word_align(pc_reg);
  assign req_fire    = req_valid_o && req_ready_i;

  assign push       = rsp_valid_i && !redirect_i && (discard_reg == '0);
  assign pop        = valid_o && ready_i && !redirect_i;
  assign push_entry = {rsp_pc_reg, rsp_data_i};

  assign valid_o = !empty;
  assign pc_o    = head.pc;
  assign inst_o  = head.inst;

  always_comb begin
    pc_next          = pc_reg;
    rsp_pc_next      = rsp_pc_reg;
    discard_next     = discard_reg;
    outstanding_next = outstanding_reg + CW'(req_fire) - CW'(rsp_valid_i);
    if (redirect_i) begin
      // Everything still in flight belongs to the old path.
      pc_next      = word_align(redirect_pc_i);
      rsp_pc_next  = word_align(redirect_pc_i);
      discard_next = outstanding_next;
    end else begin
      if (req_fire)
        pc_next = pc_reg + 32'd4;
      if (push)
        rsp_pc_next = rsp_pc_reg + 32'd4;
      if (rsp_valid_i && (discard_reg != '0))
        discard_next = discard_reg - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_reg          <= RESET_PC;
      rsp_pc_reg      <= RESET_PC;
      outstanding_reg <= '0;
      discard_reg     <= '0;
    end else begin
      pc_reg          <= pc_next;
      rsp_pc_reg      <= rsp_pc_next;
      outstanding_reg <= outstanding_next;
      discard_reg     <= discard_next;
    end
  end

  if_fetch_inst_fifo #(
    .DEPTH (DEPTH),
    .CW    (CW)
  ) u_inst_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .pop     (pop),
    .flush   (redirect_i),
    .wr_data (push_entry),
    .rd_data (head),
    .count   (count),
    .empty   (empty)
  );

  a_rsp_has_request: assert property (@(posedge clk) disable iff (rst)
    rsp_valid_i |-> (outstanding_reg != '0));

  a_credit_bound: assert property (@(posedge clk) disable iff (rst)
    in_use <= (CW + 1)'(DEPTH));

endmodule

// File: tb/tb_if_fetch.sv
// Randomized bench for if_fetch: an in-order memory model plus an epoch-tagged
// reference of what decode should see, checked every cycle.
module tb_if_fetch;
  import if_fetch_pkg::*;

  localparam int          DEPTH  = 2;
  localparam logic [31:0] RST_PC = 32'h1c00_0000;

  logic        clk = 1'b0;
  logic        rst, redirect_i, req_valid_o, req_ready_i, rsp_valid_i, valid_o, ready_i;
  logic [31:0] redirect_pc_i, req_addr_o, rsp_data_i, pc_o, inst_o;

  if_fetch #(.DEPTH(DEPTH), .RESET_PC(RST_PC)) dut (
    .clk           (clk),
    .rst           (rst),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .req_valid_o   (req_valid_o),
    .req_ready_i   (req_ready_i),
    .req_addr_o    (req_addr_o),
    .rsp_valid_i   (rsp_valid_i),
    .rsp_data_i    (rsp_data_i),
    .valid_o       (valid_o),
    .ready_i       (ready_i),
    .pc_o          (pc_o),
    .inst_o        (inst_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          epoch;
    int          due;
  } mem_req_t;

  mem_req_t    mem_q[$];   // accepted requests awaiting a response
  logic [31:0] buf_q[$];   // PCs decode should see next, in order
  int          epoch, cyc, mem_lat, checks, errors;
  logic [31:0] req_exp;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9e37_79b1) ^ 32'hc0de_0000;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One clock: drive inputs after the edge, compare against the model mid-cycle.
  task automatic run_cycle(input bit rst_v, input bit redir, input logic [31:0] tgt,
                           input bit rdy, input bit rq_rdy);
    bit       exp_req;
    mem_req_t m;
    @(posedge clk);
    #1;
    rst           = rst_v;
    redirect_i    = redir;
    redirect_pc_i = tgt;
    ready_i       = rdy;
    req_ready_i   = rq_rdy;
    rsp_valid_i   = 1'b0;
    rsp_data_i    = $urandom;
    if (!rst_v && mem_q.size() != 0 && mem_q[0].due <= cyc) begin
      rsp_valid_i = 1'b1;
      rsp_data_i  = mem_word(mem_q[0].addr);
    end
    @(negedge clk);
    if (rst_v) begin
      check_eq("req_valid_in_reset", req_valid_o, 0);
      mem_q.delete();
      buf_q.delete();
      epoch++;
      req_exp = RST_PC;
    end else begin
      check_eq("valid_o", valid_o, buf_q.size() != 0);
      if (buf_q.size() != 0) begin
        check_eq("pc_o", pc_o, buf_q[0]);
        check_eq("inst_o", inst_o, mem_word(buf_q[0]));
      end else begin
        check_eq("pc_o_empty", pc_o, 0);
        check_eq("inst_o_empty", inst_o, 0);
      end
      exp_req = !redir && (buf_q.size() + mem_q.size() < DEPTH);
      check_eq("req_valid_o", req_valid_o, exp_req);
      if (exp_req) begin
        check_eq("req_addr_o", req_addr_o, req_exp);
        if (rq_rdy) begin
          m.addr  = req_exp;
          m.epoch = epoch;
          m.due   = cyc + mem_lat;
          mem_q.push_back(m);
          req_exp += 32'd4;
        end
      end
      if (redir) begin
        if (rsp_valid_i) void'(mem_q.pop_front());
        buf_q.delete();
        epoch++;
        req_exp = tgt & 32'hffff_fffc;
        $display("redirect target=%08h", tgt);
      end else begin
        if (rdy && buf_q.size() != 0) begin
          $display("deliver pc=%08h inst=%08h", pc_o, inst_o);
          void'(buf_q.pop_front());
        end
        if (rsp_valid_i) begin
          m = mem_q.pop_front();
          if (m.epoch == epoch) buf_q.push_back(m.addr);
        end
      end
    end
    cyc++;
  endtask

  initial begin
    bit          r_rst, r_redir, r_rdy, r_rq;
    logic [31:0] r_tgt;
    rst = 1'b1; redirect_i = 1'b0; redirect_pc_i = '0; req_ready_i = 1'b0;
    rsp_valid_i = 1'b0; rsp_data_i = '0; ready_i = 1'b0;
    checks = 0; errors = 0; cyc = 0; epoch = 0; mem_lat = 1; req_exp = RST_PC;

    repeat (3) run_cycle(1, 0, 0, 1, 1);
    // Streaming with a 1-cycle memory and decode always ready.
    repeat (20) run_cycle(0, 0, 0, 1, 1);
    // Decode stall: buffer fills, requests stop; then drain.
    repeat (10) run_cycle(0, 0, 0, 0, 1);
    repeat (10) run_cycle(0, 0, 0, 1, 1);

    // Redirect while two requests are in flight.
    mem_lat = 3;
    for (int i = 0; i < 20 && mem_q.size() != 2; i++) run_cycle(0, 0, 0, 1, 1);
    check_eq("two_in_flight_reached", mem_q.size() == 2, 1);
    run_cycle(0, 1, 32'h1c00_0103, 1, 1);
    repeat (15) run_cycle(0, 0, 0, 1, 1);

    // Memory accept toggling every cycle.
    for (int i = 0; i < 40; i++) run_cycle(0, 0, 0, 1, i[0]);

    // Back-to-back redirects: the later one wins.
    run_cycle(0, 1, 32'h1c00_0200, 1, 1);
    run_cycle(0, 1, 32'h1c00_0300, 1, 1);
    repeat (15) run_cycle(0, 0, 0, 1, 1);

    // Reset together with a redirect in mid-stream.
    run_cycle(1, 1, 32'h1c00_0500, 1, 1);
    repeat (12) run_cycle(0, 0, 0, 1, 1);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      if (i % 200 == 0) mem_lat = int'($urandom_range(1, 4));
      r_rst   = ($urandom_range(0, 199) == 0);
      r_redir = ($urandom_range(0, 99) < 3);
      r_tgt   = 32'h1c00_0000 | ($urandom & 32'h0000_ffff);
      r_rdy   = ($urandom_range(0, 3) != 0);
      r_rq    = ($urandom_range(0, 2) != 0);
      run_cycle(r_rst, r_redir, r_tgt, r_rdy, r_rq);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
